// File: rtl/line_feeder_if.sv
// line_feeder_if: pixel-stream and window-column bundle for line_feeder.
//   pix_in     : incoming pixel, raster order        (master -> slave)
//   pix_valid  : pix_in valid                        (master -> slave)
//   hold       : downstream pause, blocks acceptance (master -> slave)
//   pix_ready  : slave can accept pix_in             (slave -> master)
//   l1_out     : pixel at (row-2, col)               (slave -> master)
//   l2_out     : pixel at (row-1, col)               (slave -> master)
//   l3_out     : pixel at (row, col)                 (slave -> master)
//   wr_sft_en  : one-cycle window shift strobe       (slave -> master)
//   win_valid  : window holds a full 3x3 after shift (slave -> master)
//   frame_done : one-cycle end-of-frame pulse        (slave -> master)
//
// Handshake: a pixel transfers on a rising clk edge where pix_valid and
// pix_ready are both 1. The master holds pix_in stable while pix_valid is
// high and not yet accepted; pix_ready never depends on pix_valid.
interface line_feeder_if #(
    parameter int BIT_DEPTH = 8
);
    logic [BIT_DEPTH-1:0] pix_in;
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 hold;
    logic [BIT_DEPTH-1:0] l1_out;
    logic [BIT_DEPTH-1:0] l2_out;
    logic [BIT_DEPTH-1:0] l3_out;
    logic                 wr_sft_en;
    logic                 win_valid;
    logic                 frame_done;

    modport master (
        output pix_in, pix_valid, hold,
        input  pix_ready, l1_out, l2_out, l3_out, wr_sft_en, win_valid, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, hold,
        output pix_ready, l1_out, l2_out, l3_out, wr_sft_en, win_valid, frame_done
    );
endinterface

// File: rtl/line_feeder.sv
// line_feeder: front end of the 3x3 sliding-window path.
// Keeps the two previous image lines in column-indexed line buffers and, for
// every accepted pixel, emits the vertically aligned column (row-2, row-1,
// row) one cycle later together with a shift strobe for the window register.
// Ports:
//   clk         : clock, all logic on rising edge
//   rst         : synchronous reset, active-low
//   bus         : line_feeder_if.slave (pixel handshake + window column)
//   o_dbg_state : current FSM state (0=FILL, 1=STREAM, 2=DONE)
module line_feeder #(
    parameter int BIT_DEPTH = 8,
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8
) (
    input  logic          clk,
    input  logic          rst,
    line_feeder_if.slave  bus,
    output logic [1:0]    o_dbg_state
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_col;
    logic [RW-1:0]        r_row;
    logic [BIT_DEPTH-1:0] r_buf_a [IMG_W];
    logic [BIT_DEPTH-1:0] r_buf_b [IMG_W];
    logic [BIT_DEPTH-1:0] r_l1;
    logic [BIT_DEPTH-1:0] r_l2;
    logic [BIT_DEPTH-1:0] r_l3;
    logic                 r_sft;
    logic                 r_win;

    logic w_ready;
    logic w_accept;
    logic w_col_last;
    logic w_row_last;
    logic w_frame_last;

    // Ready is gated by rst so nothing is taken while reset is held.
    assign w_ready      = rst && !bus.hold && (r_state != S_DONE);
    assign w_accept     = w_ready && bus.pix_valid;
    assign w_col_last   = (r_col == CW'(IMG_W - 1));
    assign w_row_last   = (r_row == RW'(IMG_H - 1));
    assign w_frame_last = w_accept && w_col_last && w_row_last;

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line buffers are deliberately not reset; rows 0-1 of every frame never
    // raise win_valid, so stale contents are never flagged as a valid window.
    // Reads below use the pre-edge values, so the column shift buf_b->buf_a
    // and the outputs both see the old data at the same index.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf_a[r_col] <= r_buf_b[r_col];
            r_buf_b[r_col] <= bus.pix_in;
        end
    end

    // Registered column outputs; they hold while no shift is issued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_l1  <= '0;
            r_l2  <= '0;
            r_l3  <= '0;
            r_sft <= 1'b0;
            r_win <= 1'b0;
        end else begin
            r_sft <= w_accept;
            r_win <= w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));
            if (w_accept) begin
                r_l1 <= r_buf_a[r_col];
                r_l2 <= r_buf_b[r_col];
                r_l3 <= bus.pix_in;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FILL: begin
                // Last pixel of row 1 moves the frame into the valid-window region.
                if (w_accept && w_col_last && (r_row == RW'(1))) begin
                    w_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_frame_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_FILL;
            default: w_next = S_FILL;
        endcase
    end

    // FSM / datapath outputs.
    always_comb begin
        bus.pix_ready  = w_ready;
        bus.frame_done = (r_state == S_DONE);
        o_dbg_state    = r_state;
    end

    assign bus.l1_out    = r_l1;
    assign bus.l2_out    = r_l2;
    assign bus.l3_out    = r_l3;
    assign bus.wr_sft_en = r_sft;
    assign bus.win_valid = r_win;

endmodule

// File: doc/line_feeder.md
Name: line_feeder

Overview:
- Front end of the 3x3 sliding-window path.
- Accepts a raster-order pixel stream over a valid/ready handshake and keeps the two previous image lines in internal line buffers.
- Each accepted pixel produces three vertically aligned pixels (row-2, row-1, row) plus a shift enable, which drive the window shift register.
- Flags when the window holds a complete 3x3 neighbourhood, and flags end of frame.

Parameters:
BIT_DEPTH, 8, pixel width in bits
IMG_W, 8, pixels per line (>=3)
IMG_H, 8, lines per frame (>=3)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
pix_in  input  BIT_DEPTH  incoming pixel, raster order
pix_valid  input  1  pix_in valid
pix_ready  output  1  block can accept pix_in
hold  input  1  downstream pause; forces pix_ready low
l1_out  output  BIT_DEPTH  pixel at (row-2, col), top window row
l2_out  output  BIT_DEPTH  pixel at (row-1, col)
l3_out  output  BIT_DEPTH  pixel at (row, col), the accepted pixel
wr_sft_en  output  1  one-cycle shift strobe for the window register
win_valid  output  1  after this shift the window holds a full 3x3
frame_done  output  1  one-cycle pulse after the last pixel of a frame

Behaviour:
- Reset (rst=0 at clk edge): l1_out/l2_out/l3_out=0, wr_sft_en=0, win_valid=0, frame_done=0, pix_ready=0; col=0, row=0, state=FILL. Line buffer contents are not reset and may hold stale data.
- Reset mid-frame abandons the frame. The next accepted pixel is (0,0).
- Accept: a pixel is accepted when pix_valid && pix_ready at a clk edge.
- pix_ready = (state != DONE) && !hold && rst deasserted. It is 1 in the first cycle after reset release (if hold=0).
- Line buffers: two IMG_W-deep arrays, buf_a (row-2) and buf_b (row-1), indexed by col.
- On accept, same edge:
  - l1_out<=buf_a[col], l2_out<=buf_b[col], l3_out<=pix_in.
  - buf_a[col]<=buf_b[col], buf_b[col]<=pix_in.
  - Read-before-write at the same index: outputs use the old values.
- Latency: outputs and wr_sft_en are registered and appear the cycle after accept. wr_sft_en is exactly one cycle per accepted pixel; it is 0 in cycles with no accept.
- l*_out hold their last value when wr_sft_en=0.
- win_valid is registered with wr_sft_en and equals (row>=2 && col>=2) of the accepted pixel. It is 0 whenever wr_sft_en=0.
- Counters:
  - col increments per accept and wraps IMG_W-1 -> 0.
  - On wrap, row increments.
  - On accepting (IMG_H-1, IMG_W-1), row and col both return to 0.
- FSM:
  - FILL (row<2): stream normally, win_valid always 0. Moves to STREAM when row becomes 2.
  - STREAM (row>=2): stream normally. Moves to DONE on accepting the last pixel of the frame.
  - DONE: one cycle. frame_done=1, pix_ready=0 (coincident with the last wr_sft_en). Then moves to FILL.
- No other backpressure. Downstream must absorb one shift per cycle.
- hold asserted mid-line: counters and outputs freeze and no data is lost.
- Simultaneous hold=1 and pix_valid=1: no accept.
- Line buffers are not cleared between frames. Rows 0-1 of each frame never assert win_valid, so stale data is never flagged valid.

Test Plan (IMG_W=4, IMG_H=4, BIT_DEPTH=8; pixel (r,c)=r*16+c):
- Reset: hold rst=0 for 2 cycles with pix_valid=1 -> all outputs 0, pix_ready=0, nothing accepted. Release -> pix_ready=1 next cycle.
- Fill: stream rows 0-1 (0x00..0x13) back-to-back -> 8 wr_sft_en pulses, each 1 cycle after accept, win_valid=0 on all. At the pixel 0x13 pulse, l3_out=0x13 and l2_out=0x03.
- Window valid: stream row 2 -> win_valid=0 for 0x20 and 0x21. For 0x22, the next cycle shows l1_out=0x02, l2_out=0x12, l3_out=0x22, wr_sft_en=1, win_valid=1.
- Gaps/hold: toggle pix_valid every other cycle during row 3, and assert hold for 3 cycles mid-row.
  - wr_sft_en only after real accepts; pix_ready=0 while hold=1; outputs hold their value.
  - Sequence continues correctly with 0x32, 0x33.
- End of frame: accept 0x33 -> next cycle l1_out=0x13, l2_out=0x23, l3_out=0x33, win_valid=1, frame_done=1, pix_ready=0. The cycle after, pix_ready=1 and the next frame's pixel 0x00 is accepted with win_valid=0.
- Reset mid-frame: after 6 accepts, pulse rst=0 for 1 cycle, then send a new frame -> win_valid stays 0 until new pixel (2,2). frame_done only after 16 new accepts.
